// File: rtl/commit_monitor.sv
// commit_monitor: retirement-stream monitor for a processor core.
// Counts cycles, commits and dropped trace records, buffers {pc, instr, seq}
// records in a trace FIFO, and stops counting once the halt PC retires.
// Optional per-opcode commit histogram, enabled by defining
// COMMIT_MONITOR_OPCODE_HIST_EN; the default build ties hist_count_o to 0.
module commit_monitor #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    INSTR_WIDTH = 32,
  parameter int                    FIFO_DEPTH  = 8,
  parameter int                    CNT_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] HALT_PC     = 'h3d
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clear_i,
  input  logic                   commit_valid_i,
  input  logic [ADDR_WIDTH-1:0]  commit_pc_i,
  input  logic [INSTR_WIDTH-1:0] commit_instr_i,
  output logic                   trace_valid_o,
  input  logic                   trace_ready_i,
  output logic [ADDR_WIDTH-1:0]  trace_pc_o,
  output logic [INSTR_WIDTH-1:0] trace_instr_o,
  output logic [CNT_WIDTH-1:0]   trace_seq_o,
  output logic [CNT_WIDTH-1:0]   cycles_o,
  output logic [CNT_WIDTH-1:0]   instrs_o,
  output logic [CNT_WIDTH-1:0]   drops_o,
  output logic                   overflow_o,
  output logic                   done_o,
  input  logic [3:0]             hist_sel_i,
  output logic [CNT_WIDTH-1:0]   hist_count_o
);

  localparam int                PTR_W   = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0]    PTR_ONE = {{PTR_W{1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Saturating increment shared by every counter: all-ones is sticky.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : (v + CNT_ONE);
  endfunction

  state_t                 r_state;
  state_t                 w_state_nxt;

  logic [PTR_W:0]         r_wptr;
  logic [PTR_W:0]         r_rptr;
  logic [ADDR_WIDTH-1:0]  r_mem_pc    [FIFO_DEPTH];
  logic [INSTR_WIDTH-1:0] r_mem_instr [FIFO_DEPTH];
  logic [CNT_WIDTH-1:0]   r_mem_seq   [FIFO_DEPTH];

  logic [CNT_WIDTH-1:0]   r_cycles;
  logic [CNT_WIDTH-1:0]   r_instrs;
  logic [CNT_WIDTH-1:0]   r_drops;
  logic                   r_overflow;

  logic                   w_empty;
  logic                   w_full;
  logic                   w_pop;
  logic                   w_commit;
  logic                   w_push;
  logic                   w_drop;
  logic                   w_halt_hit;

  // FIFO occupancy comes from the extra pointer bit: equal pointers mean
  // empty, equal index with opposite wrap bit means full.
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[PTR_W] != r_rptr[PTR_W]) &&
                   (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);

  // clear_i discards both a pop and a commit arriving in the same cycle.
  assign w_pop      = !w_empty && trace_ready_i && !clear_i;
  assign w_commit   = commit_valid_i && (r_state == ST_RUN) && !clear_i;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_push     = w_commit && (!w_full || w_pop);
  assign w_drop     = w_commit && w_full && !w_pop;
  assign w_halt_hit = w_commit && (commit_pc_i == HALT_PC);

  // Run-state register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= ST_RUN;
    else        r_state <= w_state_nxt;
  end

  // Next-state: halt commit ends RUN; DRAIN finishes one cycle after empty.
  always_comb begin
    w_state_nxt = r_state;
    if (clear_i) begin
      w_state_nxt = ST_RUN;
    end else begin
      case (r_state)
        ST_RUN:   if (w_halt_hit) w_state_nxt = ST_DRAIN;
        ST_DRAIN: if (w_empty)    w_state_nxt = ST_DONE;
        ST_DONE:  w_state_nxt = ST_DONE;
        default:  w_state_nxt = ST_RUN;
      endcase
    end
  end

  // FIFO pointers; they wrap naturally modulo 2*FIFO_DEPTH.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (clear_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
    end
  end

  // Record storage; contents are only observable through the valid-gated head.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem_pc[r_wptr[PTR_W-1:0]]    <= commit_pc_i;
      r_mem_instr[r_wptr[PTR_W-1:0]] <= commit_instr_i;
      r_mem_seq[r_wptr[PTR_W-1:0]]   <= r_instrs;
    end
  end

  // Performance counters and sticky overflow flag.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_cycles   <= '0;
      r_instrs   <= '0;
      r_drops    <= '0;
      r_overflow <= 1'b0;
    end else if (clear_i) begin
      r_cycles   <= '0;
      r_instrs   <= '0;
      r_drops    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (r_state == ST_RUN) r_cycles <= sat_inc(r_cycles);
      if (w_commit)          r_instrs <= sat_inc(r_instrs);
      if (w_drop) begin
        r_drops    <= sat_inc(r_drops);
        r_overflow <= 1'b1;
      end
    end
  end

  assign trace_valid_o = !w_empty;
  assign trace_pc_o    = trace_valid_o ? r_mem_pc[r_rptr[PTR_W-1:0]]    : '0;
  assign trace_instr_o = trace_valid_o ? r_mem_instr[r_rptr[PTR_W-1:0]] : '0;
  assign trace_seq_o   = trace_valid_o ? r_mem_seq[r_rptr[PTR_W-1:0]]   : '0;
  assign cycles_o      = r_cycles;
  assign instrs_o      = r_instrs;
  assign drops_o       = r_drops;
  assign overflow_o    = r_overflow;
  assign done_o        = (r_state == ST_DONE);

`ifdef COMMIT_MONITOR_OPCODE_HIST_EN
  logic [CNT_WIDTH-1:0] r_hist [16];

  // One saturating counter per opcode, bumped on every counted commit.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < 16; i++) r_hist[i] <= '0;
    end else if (clear_i) begin
      for (int i = 0; i < 16; i++) r_hist[i] <= '0;
    end else if (w_commit) begin
      r_hist[commit_instr_i[3:0]] <= sat_inc(r_hist[commit_instr_i[3:0]]);
    end
  end

  assign hist_count_o = r_hist[hist_sel_i];
`else
  logic w_unused_hist_sel;

  assign w_unused_hist_sel = ^hist_sel_i;
  assign hist_count_o      = '0;
`endif

endmodule

// File: tb/tb_commit_monitor.sv
// Testbench for commit_monitor: directed steps plus randomized traffic,
// checked every cycle against a queue-based reference model.
module tb_commit_monitor;

  localparam int          DEPTH = 8;
  localparam logic [31:0] HALT  = 32'h3d;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] seq;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst_i, clear_i, commit_valid_i, trace_ready_i;
  logic [31:0] commit_pc_i, commit_instr_i;
  logic [3:0]  hist_sel_i;
  logic        trace_valid_o, overflow_o, done_o;
  logic [31:0] trace_pc_o, trace_instr_o, trace_seq_o;
  logic [31:0] cycles_o, instrs_o, drops_o, hist_count_o;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state
  rec_t        mq[$];
  logic [31:0] m_cycles, m_instrs, m_drops;
  logic [31:0] mh [16];
  bit          m_ovf, m_halted, m_done;

  always #5 clk = ~clk;

  commit_monitor #(
    .ADDR_WIDTH(32), .INSTR_WIDTH(32), .FIFO_DEPTH(DEPTH),
    .CNT_WIDTH(32), .HALT_PC(HALT)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i),
    .commit_valid_i(commit_valid_i), .commit_pc_i(commit_pc_i),
    .commit_instr_i(commit_instr_i),
    .trace_valid_o(trace_valid_o), .trace_ready_i(trace_ready_i),
    .trace_pc_o(trace_pc_o), .trace_instr_o(trace_instr_o),
    .trace_seq_o(trace_seq_o),
    .cycles_o(cycles_o), .instrs_o(instrs_o), .drops_o(drops_o),
    .overflow_o(overflow_o), .done_o(done_o),
    .hist_sel_i(hist_sel_i), .hist_count_o(hist_count_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_cycles = '0; m_instrs = '0; m_drops = '0;
    m_ovf = 1'b0; m_halted = 1'b0; m_done = 1'b0;
    for (int i = 0; i < 16; i++) mh[i] = '0;
  endtask

  task automatic check_model();
    rec_t        h;
    logic [31:0] hexp;
    h.pc = '0; h.instr = '0; h.seq = '0;
    if (mq.size() > 0) h = mq[0];
`ifdef COMMIT_MONITOR_OPCODE_HIST_EN
    hexp = mh[hist_sel_i];
`else
    hexp = '0;
`endif
    chk("trace_valid", 32'(trace_valid_o), 32'(mq.size() > 0));
    chk("trace_pc",    trace_pc_o,    h.pc);
    chk("trace_instr", trace_instr_o, h.instr);
    chk("trace_seq",   trace_seq_o,   h.seq);
    chk("cycles",      cycles_o,      m_cycles);
    chk("instrs",      instrs_o,      m_instrs);
    chk("drops",       drops_o,       m_drops);
    chk("overflow",    32'(overflow_o), 32'(m_ovf));
    chk("done",        32'(done_o),     32'(m_done));
    chk("hist",        hist_count_o,  hexp);
  endtask

  // Drive one cycle of inputs, advance the model by the spec rules, check.
  task automatic step(input bit cv, input logic [31:0] pc, input logic [31:0] instr,
                      input bit rdy, input bit clr, input logic [3:0] sel);
    bit   pop, push, nd;
    rec_t r;
    commit_valid_i = cv; commit_pc_i = pc; commit_instr_i = instr;
    trace_ready_i = rdy; clear_i = clr; hist_sel_i = sel;
    push = 1'b0;
    if (clr) begin
      model_reset();
    end else begin
      pop = (mq.size() > 0) && rdy;
      nd  = m_done || (m_halted && mq.size() == 0);
      if (!m_halted) begin
        m_cycles++;
        if (cv) begin
          r.pc = pc; r.instr = instr; r.seq = m_instrs;
          m_instrs++;
          mh[instr[3:0]]++;
          if (mq.size() == DEPTH && !pop) begin
            m_drops++;
            m_ovf = 1'b1;
          end else begin
            push = 1'b1;
          end
          if (pc == HALT) m_halted = 1'b1;
        end
      end
      if (pop)  void'(mq.pop_front());
      if (push) mq.push_back(r);
      m_done = nd;
    end
    @(posedge clk);
    #1;
    check_model();
  endtask

  initial begin
    logic [31:0] saved_cycles;
    logic [31:0] rpc;
    bit          rcv, rrdy, rclr;

    rst_i = 1'b0; clear_i = 1'b0; commit_valid_i = 1'b0;
    commit_pc_i = '0; commit_instr_i = '0; trace_ready_i = 1'b1; hist_sel_i = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_model();
    rst_i = 1'b1;

    // Idle after reset
    repeat (10) step(0, 0, 0, 1, 0, 0);
    chk("idle_cycles", cycles_o, 32'd10);
    chk("idle_instrs", instrs_o, 32'd0);
    chk("idle_valid",  32'(trace_valid_o), 32'd0);

    // Back-to-back commits, consumer always ready
    step(1, 32'd4,  32'h446F1, 1, 0, 0);
    chk("b2b_seq0", trace_seq_o, 32'd0);
    step(1, 32'd8,  32'h4470,  1, 0, 0);
    chk("b2b_seq1", trace_seq_o, 32'd1);
    step(1, 32'd12, 32'h4470,  1, 0, 0);
    chk("b2b_seq2", trace_seq_o, 32'd2);
    chk("b2b_instrs", instrs_o, 32'd3);
    step(0, 0, 0, 1, 0, 0);

    // Overflow: 10 commits into an 8-deep FIFO with no consumer
    for (int k = 0; k < 10; k++) step(1, 32'(16 + 4 * k), $urandom, 0, 0, 0);
    chk("ovf_drops",  drops_o, 32'd2);
    chk("ovf_flag",   32'(overflow_o), 32'd1);
    chk("ovf_instrs", instrs_o, 32'd13);
    chk("ovf_head",   trace_seq_o, 32'd3);
    step(1, 32'h200, $urandom, 1, 0, 0);
    chk("full_pop_drops", drops_o, 32'd2);
    chk("full_pop_head",  trace_seq_o, 32'd4);

    // Clear wins over a simultaneous commit and pop
    step(1, 32'h204, $urandom, 1, 1, 0);
    chk("clr_cycles", cycles_o, 32'd0);
    chk("clr_instrs", instrs_o, 32'd0);
    chk("clr_ovf",    32'(overflow_o), 32'd0);
    chk("clr_valid",  32'(trace_valid_o), 32'd0);
    step(0, 0, 0, 1, 0, 0);
    chk("clr_run", cycles_o, 32'd1);

    // Randomized traffic with occasional halts and clears
    for (int ph = 0; ph < 3; ph++) begin
      for (int n = 0; n < 150; n++) begin
        rcv  = ($urandom_range(0, 3) != 0);
        rpc  = ($urandom_range(0, 24) == 0) ? HALT : ($urandom & 32'hFFFF_FFFC);
        rrdy = (ph == 0) ? ($urandom_range(0, 3) == 0) :
               (ph == 1) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 3) != 0);
        rclr = m_done ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 79) == 0);
        step(rcv, rpc, $urandom, rrdy, rclr, 4'($urandom_range(0, 15)));
      end
    end

    // Opcode histogram
    step(0, 0, 0, 1, 1, 0);
    for (int k = 0; k < 5; k++) step(1, 32'(32'h400 + 4 * k), 32'h10, 1, 0, 0);
    for (int k = 0; k < 2; k++) step(1, 32'(32'h500 + 4 * k), 32'h21, 1, 0, 0);
    step(0, 0, 0, 1, 0, 4'd0);
`ifdef COMMIT_MONITOR_OPCODE_HIST_EN
    chk("hist_add", hist_count_o, 32'd5);
    step(0, 0, 0, 1, 0, 4'd1);
    chk("hist_lw",  hist_count_o, 32'd2);
`else
    chk("hist_add", hist_count_o, 32'd0);
    step(0, 0, 0, 1, 0, 4'd1);
    chk("hist_lw",  hist_count_o, 32'd0);
`endif
    step(0, 0, 0, 1, 0, 4'd9);
    chk("hist_none", hist_count_o, 32'd0);

    // Halt with three records buffered, then drain
    step(0, 0, 0, 1, 1, 0);
    for (int k = 0; k < 3; k++) step(1, 32'(32'h100 + 4 * k), $urandom, 0, 0, 0);
    step(1, HALT, $urandom, 0, 0, 0);
    saved_cycles = m_cycles;
    for (int k = 0; k < 5; k++) step(1, 32'h600, $urandom, 0, 0, 0);
    chk("drain_cycles", cycles_o, saved_cycles);
    chk("drain_instrs", instrs_o, 32'd4);
    chk("drain_head",   trace_seq_o, 32'd0);
    chk("drain_done",   32'(done_o), 32'd0);
    for (int k = 0; k < 4; k++) step(0, 0, 0, 1, 0, 0);
    chk("drain_empty",    32'(trace_valid_o), 32'd0);
    chk("drain_not_done", 32'(done_o), 32'd0);
    step(0, 0, 0, 1, 0, 0);
    chk("drain_done_set", 32'(done_o), 32'd1);
    chk("drain_cycles2",  cycles_o, saved_cycles);

    // Asynchronous reset in the middle of traffic
    step(0, 0, 0, 1, 1, 0);
    for (int k = 0; k < 6; k++) step(1, 32'(32'h700 + 4 * k), $urandom, 0, 0, 0);
    #2;
    rst_i = 1'b0;
    #1;
    model_reset();
    check_model();
    @(posedge clk);
    #1;
    rst_i = 1'b1;
    commit_valid_i = 1'b0;
    for (int n = 0; n < 40; n++)
      step($urandom_range(0, 1) == 1, $urandom & 32'hFFFF_FFFC, $urandom,
           $urandom_range(0, 1) == 1, 0, 4'($urandom_range(0, 15)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
